// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller:
//   - RV32 major opcode constants used by the rs-usage decode
//   - writeback-source code that marks a load
//   - fwd_sel_e : EX operand source select (REG / MEM / WB)
//   - shadow_t  : per-stage shadow record {vld, wr, ld, rd, rs1, rs2}
//   - producer_hit / fwd_pick helpers shared by the hazard and forward logic
// Optional feature macro used by the importing RTL: HAZARD_FORWARD_EN
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // RUDataWrSrc value selecting memory read data, i.e. a load
    localparam logic [1:0] WRSRC_LOAD = 2'b01;

    typedef enum logic [1:0] {
        REG = 2'b00,
        MEM = 2'b01,
        WB  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic       vld;
        logic       wr;
        logic       ld;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } shadow_t;

    // A stage produces a value for rs only if it is a live writer of a
    // non-x0 destination equal to rs.
    function automatic logic producer_hit(input shadow_t p, input logic [4:0] rs);
        return p.vld && p.wr && (p.rd != 5'd0) && (p.rd == rs);
    endfunction

    // MEM is younger than WB, so it wins when both hold the register.
    function automatic fwd_sel_e fwd_pick(input shadow_t mem_p, input shadow_t wb_p,
                                          input logic [4:0] rs);
        fwd_sel_e sel;
        if (producer_hit(mem_p, rs)) begin
            sel = MEM;
        end else if (producer_hit(wb_p, rs)) begin
            sel = WB;
        end else begin
            sel = REG;
        end
        return sel;
    endfunction

endpackage

// File: rtl/rs_use_dec.sv
// -----------------------------------------------------------------------------
// rs_use_dec
// Combinational register-field decode of the instruction held in decode.
// Ports:
//   inst_i       : 32-bit instruction
//   rs1_o/rs2_o  : source register fields
//   rd_o         : destination register field
//   rs1_used_o   : rs1 is a real operand (not for LUI, AUIPC, JAL)
//   rs2_used_o   : rs2 is a real operand (only R, S and B formats)
// -----------------------------------------------------------------------------
module rs_use_dec
    import hazard_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic        rs1_used_o,
    output logic        rs2_used_o
);

    logic [6:0] opcode_s;
    logic       unused_bits_s;

    assign opcode_s = inst_i[6:0];
    assign rs1_o    = inst_i[19:15];
    assign rs2_o    = inst_i[24:20];
    assign rd_o     = inst_i[11:7];

    // funct3/funct7 play no part in hazard detection
    assign unused_bits_s = ^{inst_i[31:25], inst_i[14:12]};

    // Operand usage by major opcode; bits 19:15 / 24:20 are immediates otherwise
    always_comb begin
        rs1_used_o = 1'b1;
        rs2_used_o = 1'b0;
        case (opcode_s)
            OP_LUI, OP_AUIPC, OP_JAL: begin
                rs1_used_o = 1'b0;
                rs2_used_o = 1'b0;
            end
            OP_OP, OP_STORE, OP_BRANCH: begin
                rs1_used_o = 1'b1;
                rs2_used_o = 1'b1;
            end
            default: begin
                rs1_used_o = 1'b1;
                rs2_used_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Data/control hazard unit for a 5-stage in-order pipeline. Tracks a shadow
// copy of the EX, MEM and WB instructions, raises stall/flush/bubble and
// selects EX operand forwarding.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   inst_de         : instruction in decode
//   RuWr_de         : decode instruction writes a register
//   RUDataWrSrc_de  : writeback source (2'b01 = load)
//   br_taken_ex     : taken branch/jump resolved in EX
//   stall_de        : hold PC and IF/DE
//   flush_de        : clear IF/DE to NOP
//   bubble_ex       : load NOP into DE/EX
//   fwdA_sel/B_sel  : EX operand source (00 RF, 01 MEM, 10 WB)
//   stall_cnt/flush_cnt : saturating event counters (CNT_W bits)
// Build option: define HAZARD_FORWARD_EN to enable forwarding (stall only on
// load-use). Without it, any in-flight writer of a used source stalls decode.
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      inst_de,
    input  logic             RuWr_de,
    input  logic [1:0]       RUDataWrSrc_de,
    input  logic             br_taken_ex,
    output logic             stall_de,
    output logic             flush_de,
    output logic             bubble_ex,
    output logic [1:0]       fwdA_sel,
    output logic [1:0]       fwdB_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [4:0] rs1_s, rs2_s, rd_s;
    logic       rs1_used_s, rs2_used_s;

    shadow_t    ex_q, mem_q, wb_q, ex_d;
    logic       hazard_s;
    fwd_sel_e   fwd_a_s, fwd_b_s;
    logic       stall_s, flush_s, bubble_s;
    fwd_sel_e   fwd_a_out_s, fwd_b_out_s;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    rs_use_dec u_rs_use_dec (
        .inst_i     (inst_de),
        .rs1_o      (rs1_s),
        .rs2_o      (rs2_s),
        .rd_o       (rd_s),
        .rs1_used_o (rs1_used_s),
        .rs2_used_o (rs2_used_s)
    );

`ifdef HAZARD_FORWARD_EN
    // Only a load in EX cannot be forwarded in time: stall one cycle
    always_comb begin
        hazard_s = 1'b0;
        if (ex_q.ld && ((rs1_used_s && producer_hit(ex_q, rs1_s)) ||
                        (rs2_used_s && producer_hit(ex_q, rs2_s)))) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
    end

    // Operand sources for the instruction currently in EX
    always_comb begin
        fwd_a_s = fwd_pick(mem_q, wb_q, ex_q.rs1);
        fwd_b_s = fwd_pick(mem_q, wb_q, ex_q.rs2);
    end
`else
    // No forwarding: wait until every in-flight producer has left WB
    always_comb begin
        hazard_s = 1'b0;
        if ((rs1_used_s && (producer_hit(ex_q, rs1_s) || producer_hit(mem_q, rs1_s) ||
                            producer_hit(wb_q, rs1_s))) ||
            (rs2_used_s && (producer_hit(ex_q, rs2_s) || producer_hit(mem_q, rs2_s) ||
                            producer_hit(wb_q, rs2_s)))) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
    end

    // Operands always come from the register file
    always_comb begin
        fwd_a_s = REG;
        fwd_b_s = REG;
    end
`endif

    // Pipeline control; a taken branch overrides any stall, reset silences all
    always_comb begin
        stall_s     = 1'b0;
        flush_s     = 1'b0;
        bubble_s    = 1'b0;
        fwd_a_out_s = REG;
        fwd_b_out_s = REG;
        if (!rst_n) begin
            stall_s     = 1'b0;
            flush_s     = 1'b0;
            bubble_s    = 1'b0;
            fwd_a_out_s = REG;
            fwd_b_out_s = REG;
        end else if (br_taken_ex) begin
            stall_s     = 1'b0;
            flush_s     = 1'b1;
            bubble_s    = 1'b1;
            fwd_a_out_s = fwd_a_s;
            fwd_b_out_s = fwd_b_s;
        end else begin
            stall_s     = hazard_s;
            flush_s     = 1'b0;
            bubble_s    = hazard_s;
            fwd_a_out_s = fwd_a_s;
            fwd_b_out_s = fwd_b_s;
        end
    end

    // Next EX shadow: the decoded instruction, or an empty slot on stall/bubble
    always_comb begin
        ex_d = '0;
        if (!stall_s && !bubble_s) begin
            ex_d.vld = 1'b1;
            ex_d.wr  = RuWr_de;
            ex_d.ld  = RuWr_de && (RUDataWrSrc_de == WRSRC_LOAD);
            ex_d.rd  = rd_s;
            ex_d.rs1 = rs1_s;
            ex_d.rs2 = rs2_s;
        end else begin
            ex_d = '0;
        end
    end

    // Saturating next-count for both event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush_s && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Shadow pipeline advance: DE -> EX -> MEM -> WB every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // Event counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_de  = stall_s;
    assign flush_de  = flush_s;
    assign bubble_ex = bubble_s;
    assign fwdA_sel  = fwd_a_out_s;
    assign fwdB_sel  = fwd_b_out_s;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Scoreboard bench for hazard_ctrl. A driver issues directed and random
// instructions; for each cycle a reference model, kept as a history of the
// last three instructions that entered execute, pushes the expected outputs
// into a queue that an independent monitor pops and compares.
// Follows HAZARD_FORWARD_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_R     = 7'b0110011;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      inst_de;
    logic             RuWr_de;
    logic [1:0]       RUDataWrSrc_de;
    logic             br_taken_ex;
    logic             stall_de, flush_de, bubble_ex;
    logic [1:0]       fwdA_sel, fwdB_sel;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inst_de        (inst_de),
        .RuWr_de        (RuWr_de),
        .RUDataWrSrc_de (RUDataWrSrc_de),
        .br_taken_ex    (br_taken_ex),
        .stall_de       (stall_de),
        .flush_de       (flush_de),
        .bubble_ex      (bubble_ex),
        .fwdA_sel       (fwdA_sel),
        .fwdB_sel       (fwdB_sel),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        bit wr;
        bit ld;
        int rd;
        int rs1;
        int rs2;
    } ins_t;

    typedef struct {
        bit stall;
        bit flush;
        bit bubble;
        int fa;
        int fb;
        int scnt;
        int fcnt;
    } exp_t;

    exp_t exp_q[$];
    ins_t hist[$];     // [0] entered execute one cycle ago, [1] two, [2] three
    int   m_scnt, m_fcnt;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic ins_t empty_ins();
        ins_t z;
        z.v = 1'b0; z.wr = 1'b0; z.ld = 1'b0; z.rd = 0; z.rs1 = 0; z.rs2 = 0;
        return z;
    endfunction

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back(empty_ins());
        m_scnt = 0;
        m_fcnt = 0;
    endfunction

    function automatic bit hit(input ins_t p, input int rs);
        return p.v && p.wr && (p.rd != 0) && (p.rd == rs);
    endfunction

    function automatic int fwd_of(input int rs);
        if (hit(hist[1], rs)) return 1;
        if (hit(hist[2], rs)) return 2;
        return 0;
    endfunction

    function automatic void derive(input logic [31:0] inst, output bit wr, output logic [1:0] src);
        logic [6:0] op;
        op  = inst[6:0];
        wr  = !(op == OP_S || op == OP_B);
        src = (op == OP_LD) ? 2'b01 : ((op == OP_JAL || op == OP_JALR) ? 2'b10 : 2'b00);
    endfunction

    // One clock cycle of stimulus plus the model's expectation for it
    task automatic step(input logic [31:0] inst, input bit br, output bit held);
        ins_t       cur;
        exp_t       e;
        bit         u1, u2, hz, wr;
        logic [1:0] src;
        logic [6:0] op;
        derive(inst, wr, src);
        @(negedge clk);
        rst_n          = 1'b1;
        inst_de        = inst;
        RuWr_de        = wr;
        RUDataWrSrc_de = src;
        br_taken_ex    = br;
        #1;
        op      = inst[6:0];
        u1      = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
        u2      = (op == OP_R || op == OP_S || op == OP_B);
        cur.v   = 1'b1;
        cur.wr  = wr;
        cur.ld  = wr && (src == 2'b01);
        cur.rd  = int'(inst[11:7]);
        cur.rs1 = int'(inst[19:15]);
        cur.rs2 = int'(inst[24:20]);
`ifdef HAZARD_FORWARD_EN
        hz   = hist[0].ld && ((u1 && hit(hist[0], cur.rs1)) || (u2 && hit(hist[0], cur.rs2)));
        e.fa = fwd_of(hist[0].rs1);
        e.fb = fwd_of(hist[0].rs2);
`else
        hz = 1'b0;
        foreach (hist[i]) begin
            if ((u1 && hit(hist[i], cur.rs1)) || (u2 && hit(hist[i], cur.rs2))) hz = 1'b1;
        end
        e.fa = 0;
        e.fb = 0;
`endif
        e.stall  = !br && hz;
        e.flush  = br;
        e.bubble = br || hz;
        e.scnt   = m_scnt;
        e.fcnt   = m_fcnt;
        exp_q.push_back(e);
        if (e.stall && m_scnt < CNT_MAX) m_scnt++;
        if (e.flush && m_fcnt < CNT_MAX) m_fcnt++;
        void'(hist.pop_back());
        hist.push_front(e.bubble ? empty_ins() : cur);
        held = e.stall;
    endtask

    // Present an instruction until decode accepts it
    task automatic issue(input logic [31:0] inst);
        bit held;
        int n = 0;
        do begin
            step(inst, 1'b0, held);
            n++;
        end while (held && n < 8);
        if (held) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: stall still %0d after %0d cycles", held, n);
        end
    endtask

    // Assert reset at a negedge; the next step releases it
    task automatic reset_pulse();
        @(negedge clk);
        rst_n       = 1'b0;
        inst_de     = NOP;
        RuWr_de     = 1'b1;
        br_taken_ex = 1'b0;
        model_reset();
        #1;
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        chk("rst_flush_cnt", int'(flush_cnt), 0);
    endtask

    function automatic logic [31:0] rtype(input int rd, input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), OP_R};
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'd0, 5'(rd), OP_I};
    endfunction

    function automatic logic [31:0] lw(input int rd, input int rs1);
        return {12'd0, 5'(rs1), 3'b010, 5'(rd), OP_LD};
    endfunction

    // Monitor: outputs are valid every cycle; compare whatever the model queued
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall_de",  int'(stall_de),  int'(e.stall));
                chk("flush_de",  int'(flush_de),  int'(e.flush));
                chk("bubble_ex", int'(bubble_ex), int'(e.bubble));
                chk("fwdA_sel",  int'(fwdA_sel),  e.fa);
                chk("fwdB_sel",  int'(fwdB_sel),  e.fb);
                chk("stall_cnt", int'(stall_cnt), e.scnt);
                chk("flush_cnt", int'(flush_cnt), e.fcnt);
            end
        end
    end

    initial begin
        bit         held;
        logic [6:0] ops [9];
        logic [31:0] ri;
        int         wait_n;
        ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_B, OP_LD, OP_S, OP_I, OP_R};

        // Reset state, with a taken branch driven to show outputs stay quiet
        rst_n          = 1'b0;
        inst_de        = lw(5, 1);
        RuWr_de        = 1'b1;
        RUDataWrSrc_de = 2'b01;
        br_taken_ex    = 1'b1;
        model_reset();
        #3;
        chk("rst_stall_de",  int'(stall_de),  0);
        chk("rst_flush_de",  int'(flush_de),  0);
        chk("rst_bubble_ex", int'(bubble_ex), 0);
        chk("rst_fwdA",      int'(fwdA_sel),  0);
        chk("rst_fwdB",      int'(fwdB_sel),  0);

        // addi x5,x0,7 ; add x6,x5,x5
        issue(addi(5, 0, 7));
        issue(rtype(6, 5, 5));
        step(NOP, 1'b0, held);
        #2;
`ifdef HAZARD_FORWARD_EN
        chk("alu_fwdA_mem", int'(fwdA_sel), 1);
        chk("alu_fwdB_mem", int'(fwdB_sel), 1);
        chk("alu_no_stall", int'(stall_cnt), 0);
`else
        chk("nofwd_fwdA", int'(fwdA_sel), 0);
        chk("nofwd_fwdB", int'(fwdB_sel), 0);
        chk("nofwd_stall_3", int'(stall_cnt), 3);
`endif

        // lw x5,0(x1) ; add x6,x5,x2
        reset_pulse();
        issue(lw(5, 1));
        step(rtype(6, 5, 2), 1'b0, held);
        #2;
        chk("ldu_stall", int'(stall_de), 1);
        chk("ldu_bubble", int'(bubble_ex), 1);
        issue(rtype(6, 5, 2));
        step(NOP, 1'b0, held);
        #2;
`ifdef HAZARD_FORWARD_EN
        chk("ldu_fwdA_wb", int'(fwdA_sel), 2);
        chk("ldu_stall_cnt", int'(stall_cnt), 1);
`else
        chk("ldu_stall_cnt", int'(stall_cnt), 3);
`endif

        // Taken branch in the load-use cycle
        reset_pulse();
        issue(lw(5, 1));
        step(rtype(6, 5, 2), 1'b1, held);
        #2;
        chk("br_flush", int'(flush_de), 1);
        chk("br_bubble", int'(bubble_ex), 1);
        chk("br_stall", int'(stall_de), 0);
        step(NOP, 1'b0, held);
        #2;
        chk("br_flush_cnt", int'(flush_cnt), 1);
        chk("br_stall_cnt", int'(stall_cnt), 0);

        // x0 as destination never creates a dependency
        reset_pulse();
        issue(addi(0, 0, 1));
        issue(rtype(6, 0, 0));
        step(NOP, 1'b0, held);
        #2;
        chk("x0_fwdA", int'(fwdA_sel), 0);
        chk("x0_fwdB", int'(fwdB_sel), 0);
        chk("x0_stall_cnt", int'(stall_cnt), 0);

        // Reset dropped in the middle of a load-use stall
        issue(lw(5, 1));
        @(negedge clk);
        rst_n          = 1'b1;
        inst_de        = rtype(6, 5, 2);
        RuWr_de        = 1'b1;
        RUDataWrSrc_de = 2'b00;
        br_taken_ex    = 1'b0;
        #1;
        chk("mid_stall_before", int'(stall_de), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_stall_async", int'(stall_de), 0);
        chk("mid_bubble_async", int'(bubble_ex), 0);
        model_reset();
        step(rtype(6, 5, 2), 1'b0, held);
        #2;
        chk("post_rst_no_stale", int'(stall_de), 0);

        // Randomized traffic on a small register pool to provoke hazards
        for (int n = 0; n < 500; n++) begin
            ri = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  3'($urandom), 5'($urandom_range(0, 3)), ops[$urandom_range(0, 8)]};
            step(ri, ($urandom_range(0, 9) == 0), held);
            if ($urandom_range(0, 99) == 0) reset_pulse();
        end

        wait_n = 0;
        while (exp_q.size() != 0 && wait_n < 10) begin
            @(negedge clk);
            wait_n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        #5;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
